_addsub_serial: RTL and testbench

Parametrised, nibble-serial adder/subtractor: one 4-bit `_74x283` slice plus a carry flip-flop processes a WIDTH-bit operation one nibble per clock, LSB nibble first. It is the multi-cycle, low-chip-count alternative to the fully parallel ripple adder in `sim/util`. It adds a subtract mode, a start/done handshake, and carry, overflow and zero flags for the ALU and address paths.

---
 rtl/_addsub_serial_pkg.sv | 13 +
 rtl/_74x283.sv | 27 ++
 rtl/_addsub_serial.sv | 133 +++++++++++++
 tb/tb__addsub_serial.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/_addsub_serial_pkg.sv
// Shared types for the nibble-serial adder/subtractor.
// State encoding is fixed (IDLE=0, RUN=1, DONE=2) so it stays readable on a logic analyser.
package _addsub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

endpackage

// File: rtl/_74x283.sv
// 4-bit carry-lookahead adder slice, equivalent to a 74x283.
module _74x283 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c[3:0];
    c4   = c[4];
  end

endmodule

// File: rtl/_addsub_serial.sv
// Nibble-serial adder/subtractor: one 74x283 slice plus a carry flop, LSB nibble first.
// Result and flags are registered and only updated on the completing edge.
module _addsub_serial
  import _addsub_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / NIB_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
      $error("_addsub_serial: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] racc_q, racc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0]       nib_sum;
  logic             nib_co;
  logic [WIDTH-1:0] acc_next;

  _74x283 u_slice (
    .a  (ra_q[3:0]),
    .b  (rb_q[3:0]),
    .c0 (carry_q),
    .s  (nib_sum),
    .c4 (nib_co)
  );

  // The new nibble enters at the top; after N shifts the LSB nibble sits at bit 0.
  assign acc_next = WIDTH'({nib_sum, racc_q} >> NIB_W);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    racc_d  = racc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b ^ {WIDTH{sub}};
          racc_d  = '0;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        ra_d    = ra_q >> NIB_W;
        rb_d    = rb_q >> NIB_W;
        racc_d  = acc_next;
        carry_d = nib_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          s_d     = acc_next;
          cout_d  = nib_co;
          ovf_d   = (ra_q[3] == rb_q[3]) && (nib_sum[3] != ra_q[3]);
          zero_d  = ~|acc_next;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      racc_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      racc_q  <= racc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb__addsub_serial.sv
// Directed bench for _addsub_serial at WIDTH=32 and WIDTH=8.
module tb__addsub_serial;

  logic        clk;
  logic        rst_n;

  logic        start32, sub32;
  logic [31:0] a32, b32, s32;
  logic        busy32, done32, cout32, ovf32, zero32;

  logic        start8, sub8;
  logic [7:0]  a8, b8, s8;
  logic        busy8, done8, cout8, ovf8, zero8;

  int n_cmp;
  int n_err;

  _addsub_serial #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .s(s32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  _addsub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from the current negedge; returns at the negedge where done is seen.
  task automatic op32(input logic sb, input logic [31:0] av, input logic [31:0] bv,
                      output int lat, output int bcnt);
    start32 = 1'b1; sub32 = sb; a32 = av; b32 = bv;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      start32 = 1'b0;
      if (busy32) bcnt++;
    end while (!done32 && lat < 30);
  endtask

  task automatic op8(input logic sb, input logic [7:0] av, input logic [7:0] bv,
                     output int lat);
    start8 = 1'b1; sub8 = sb; a8 = av; b8 = bv;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start8 = 1'b0;
    end while (!done8 && lat < 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy32, done32, cout32, ovf32, zero32} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags32 got %b want 00000", {busy32, done32, cout32, ovf32, zero32});
    end
    n_cmp++;
    if (s32 !== 32'h0) begin n_err++; $display("FAIL reset_s32 got %h want 0", s32); end
    n_cmp++;
    if ({busy8, done8, s8, cout8, ovf8, zero8} !== 13'b0) begin
      n_err++; $display("FAIL reset_dut8 got %b want 0", {busy8, done8, s8, cout8, ovf8, zero8});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_wrap();
    int lat, bcnt;
    op32(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL wrap_latency got %0d want 9", lat); end
    n_cmp++; if (bcnt !== 8) begin n_err++; $display("FAIL wrap_busy_cycles got %0d want 8", bcnt); end
    n_cmp++; if (s32 !== 32'h0) begin n_err++; $display("FAIL wrap_s got %h want 0", s32); end
    n_cmp++; if ({cout32, zero32, ovf32} !== 3'b110) begin
      n_err++; $display("FAIL wrap_flags got c/z/v=%b want 110", {cout32, zero32, ovf32});
    end
    @(negedge clk);
    n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL wrap_done_pulse got %b want 0", done32); end
    n_cmp++; if (s32 !== 32'h0 || zero32 !== 1'b1) begin
      n_err++; $display("FAIL wrap_hold got s=%h z=%b want 0/1", s32, zero32);
    end
  endtask

  task automatic test_add_ovf();
    int lat, bcnt;
    op32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat, bcnt);
    n_cmp++; if (s32 !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_s got %h want 80000000", s32); end
    n_cmp++; if ({ovf32, cout32, zero32} !== 3'b100) begin
      n_err++; $display("FAIL ovf_flags got v/c/z=%b want 100", {ovf32, cout32, zero32});
    end
  endtask

  task automatic test_sub();
    int lat, bcnt;
    op32(1'b1, 32'h8000_0000, 32'h0000_0001, lat, bcnt);
    n_cmp++; if (s32 !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub1_s got %h want 7fffffff", s32); end
    n_cmp++; if ({ovf32, cout32, zero32} !== 3'b110) begin
      n_err++; $display("FAIL sub1_flags got v/c/z=%b want 110", {ovf32, cout32, zero32});
    end
    op32(1'b1, 32'h0000_0005, 32'h0000_0007, lat, bcnt);
    n_cmp++; if (s32 !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub2_s got %h want fffffffe", s32); end
    n_cmp++; if ({ovf32, cout32, zero32} !== 3'b000) begin
      n_err++; $display("FAIL sub2_flags got v/c/z=%b want 000", {ovf32, cout32, zero32});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic seen;
    start32 = 1'b1; sub32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h1111_1111;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (done32) seen = 1'b1;
      else begin
        start32 = lat[0];
        sub32   = ~sub32;
        a32     = a32 ^ 32'hA5A5_5A5A;
        b32     = b32 + 32'h0F0F_0F0F;
      end
    end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_first_latency got %0d want 9", lat); end
    n_cmp++; if (s32 !== 32'h2345_6789) begin n_err++; $display("FAIL b2b_first_s got %h want 23456789", s32); end
    op32(1'b1, 32'h0000_0100, 32'h0000_0001, lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_second_latency got %0d want 9", lat); end
    n_cmp++; if (s32 !== 32'h0000_00FF || cout32 !== 1'b1) begin
      n_err++; $display("FAIL b2b_second_s got s=%h c=%b want 000000ff/1", s32, cout32);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    start32 = 1'b1; sub32 = 1'b0; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy32 !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", busy32); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy32, done32, s32, cout32, ovf32, zero32} !== 37'b0) begin
      n_err++; $display("FAIL midrst_outputs got busy=%b done=%b s=%h c=%b v=%b z=%b want all 0",
                        busy32, done32, s32, cout32, ovf32, zero32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op32(1'b0, 32'h3, 32'h4, lat, bcnt);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL midrst_latency got %0d want 9", lat); end
    n_cmp++; if (s32 !== 32'h7 || zero32 !== 1'b0) begin
      n_err++; $display("FAIL midrst_s got s=%h z=%b want 00000007/0", s32, zero32);
    end
  endtask

  task automatic test_width8();
    int lat;
    op8(1'b0, 8'h0F, 8'h01, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL w8_latency got %0d want 3", lat); end
    n_cmp++; if (s8 !== 8'h10 || cout8 !== 1'b0) begin
      n_err++; $display("FAIL w8_add1 got s=%h c=%b want 10/0", s8, cout8);
    end
    op8(1'b0, 8'hFF, 8'hFF, lat);
    n_cmp++; if (s8 !== 8'hFE || cout8 !== 1'b1) begin
      n_err++; $display("FAIL w8_add2 got s=%h c=%b want fe/1", s8, cout8);
    end
    n_cmp++; if ({ovf8, zero8} !== 2'b00) begin
      n_err++; $display("FAIL w8_add2_flags got v/z=%b want 00", {ovf8, zero8});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add_wrap();
    test_add_ovf();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
